// File: rtl/prog_loader.sv
// prog_loader: boot-time byte-stream loader for the 16-bit MIPS core's instruction memory.
// It assembles big-endian 16-bit words from a valid/ready byte stream and writes them to
// the imem load port. The core is held in cpu_reset until a complete image has been written.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN. When defined, the loader expects a trailing
// XOR checksum byte over all data bytes and checks it against the received data.
module prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] HDR_HI  = 3'd0;
    localparam logic [2:0] HDR_LO  = 3'd1;
    localparam logic [2:0] DATA_HI = 3'd2;
    localparam logic [2:0] DATA_LO = 3'd3;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHK     = 3'd4;
`endif
    localparam logic [2:0] RUN     = 3'd5;
    localparam logic [2:0] ERROR   = 3'd6;

    // Image-complete target: CHK when a checksum byte follows, otherwise straight to RUN.
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] IMG_END = CHK;
`else
    localparam logic [2:0] IMG_END = RUN;
`endif

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        hi_q, hi_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       wdata_d;
    logic              rx_ready_d;
    logic              cpu_reset_d;
    logic              done_d;
    logic              err_d;

    logic              accept;
    logic [CNT_W-1:0]  n_new;
    logic [ADDR_W-1:0] last_idx;

    assign accept   = rx_valid && rx_ready;
    assign n_new    = {count_q[15:8], rx_data};
    assign last_idx = ADDR_W'(count_q - 16'd1);

    // State and datapath registers, plus the registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HDR_HI;
            count_q    <= '0;
            idx_q      <= '0;
            hi_q       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            rx_ready   <= 1'b1;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            hi_q       <= hi_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            rx_ready   <= rx_ready_d;
            cpu_reset  <= cpu_reset_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // Next-state, datapath and next-output logic; load_req overrides any byte acceptance.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        we_d    = 1'b0;
        addr_d  = imem_addr;
        wdata_d = imem_wdata;

        if (load_req) begin
            state_d = HDR_HI;
            idx_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_d   = '0;
`endif
        end else if (accept) begin
            case (state_q)
                HDR_HI: begin
                    count_d[15:8] = rx_data;
                    state_d       = HDR_LO;
                end
                HDR_LO: begin
                    count_d = n_new;
                    idx_d   = '0;
                    if (n_new == 16'd0) begin
                        state_d = IMG_END;
                    end else if (n_new > 16'(MAX_WORDS)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
                DATA_HI: begin
                    hi_d    = rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ rx_data;
`endif
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = {hi_q, rx_data};
                    idx_d   = idx_q + ADDR_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ rx_data;
`endif
                    state_d = (idx_q == last_idx) ? IMG_END : DATA_HI;
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHK: begin
                    state_d = (rx_data == chk_q) ? RUN : ERROR;
                end
`endif
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        rx_ready_d  = (state_d != RUN) && (state_d != ERROR);
        cpu_reset_d = (state_d != RUN);
        done_d      = (state_d == RUN);
        err_d       = (state_d == ERROR);
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader (either checksum build).
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        load_req;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];

    prog_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one byte (called at a negedge); returns at the negedge after it is accepted.
    task automatic send(input logic [7:0] b);
        int n;
        n        = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic gap(input int max_gap);
        int n;
        n = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        if (n > 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            repeat (n) @(negedge clk);
        end
    endtask

    // Send a whole image; chk_flip corrupts the checksum byte when non-zero.
    task automatic send_image(input logic [15:0] w [4], input int n, input int max_gap,
                              input logic [7:0] chk_flip);
        logic [7:0]  x;
        logic [15:0] cnt;
        cnt = 16'(n);
        x   = 8'h00;
        send(cnt[15:8]); gap(max_gap);
        send(cnt[7:0]);
        for (int i = 0; i < n; i++) begin
            gap(max_gap); send(w[i][15:8]);
            gap(max_gap); send(w[i][7:0]);
            x = x ^ w[i][15:8] ^ w[i][7:0];
        end
        if (CK) begin
            gap(max_gap);
            send(x ^ chk_flip);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [15:0] w [4], input int n);
        check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
            check({tag, "_data"}, 32'(wr_data_q[i]), 32'(w[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},   32'(rx_ready),   32'd1);
        check({tag, "_we"},    32'(imem_we),    32'd0);
        check({tag, "_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_cpurst"},32'(cpu_reset),  32'd1);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_err"},   32'(err),        32'd0);
    endtask

    initial begin
        logic [15:0] img_a [4];
        logic [15:0] img_b [4];
        logic [15:0] img_c [4];
        logic [15:0] img_d [4];
        int c0;

        img_a = '{16'h1234, 16'hABCD, 16'h0000, 16'h0000};
        img_b = '{16'hC0DE, 16'h5A5A, 16'h0F0F, 16'h8001};
        img_c = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        img_d = '{16'hAAAA, 16'h5555, 16'h0000, 16'h0000};

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        load_req = 1'b0;
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back two-word image.
        c0 = cyc;
        send_image(img_a, 2, 0, 8'h00);
        check("b2b_cycles", 32'(cyc - c0), CK ? 32'd7 : 32'd6);
        check("a_done",   32'(done),      32'd1);
        check("a_cpurst", 32'(cpu_reset), 32'd0);
        check("a_rdy",    32'(rx_ready),  32'd0);
        check("a_err",    32'(err),       32'd0);
        @(negedge clk);
        check_writes("a", img_a, 2);

        // Bad checksum (only meaningful with the checksum byte present).
        if (CK) begin
            pulse_load();
            wr_addr_q.delete(); wr_data_q.delete();
            send_image(img_a, 2, 0, 8'h01);
            @(negedge clk);
            check("bad_err",    32'(err),       32'd1);
            check("bad_cpurst", 32'(cpu_reset), 32'd1);
            check("bad_rdy",    32'(rx_ready),  32'd0);
            check("bad_done",   32'(done),      32'd0);
            pulse_load();
            check("bad_rl_rdy", 32'(rx_ready),  32'd1);
            check("bad_rl_err", 32'(err),       32'd0);
        end else begin
            pulse_load();
        end

        // Oversized count 0x0101.
        wr_addr_q.delete(); wr_data_q.delete();
        send(8'h01);
        send(8'h01);
        rx_valid = 1'b0;
        check("big_err",    32'(err),       32'd1);
        check("big_rdy",    32'(rx_ready),  32'd0);
        check("big_cpurst", 32'(cpu_reset), 32'd1);
        repeat (3) @(negedge clk);
        check("big_nwr",    32'(wr_addr_q.size()), 32'd0);

        // Four-word image with random rx_valid gaps.
        pulse_load();
        check("rl_err", 32'(err), 32'd0);
        wr_addr_q.delete(); wr_data_q.delete();
        send_image(img_b, 4, 3, 8'h00);
        @(negedge clk);
        check("b_done", 32'(done), 32'd1);
        check_writes("b", img_b, 4);

        // Reload from RUN with a one-word image.
        pulse_load();
        check("rl_cpurst", 32'(cpu_reset), 32'd1);
        check("rl_done",   32'(done),      32'd0);
        wr_addr_q.delete(); wr_data_q.delete();
        send_image(img_c, 1, 0, 8'h00);
        @(negedge clk);
        check("c_done",   32'(done),      32'd1);
        check("c_cpurst", 32'(cpu_reset), 32'd0);
        check_writes("c", img_c, 1);

        // Asynchronous reset after three data bytes.
        pulse_load();
        wr_addr_q.delete(); wr_data_q.delete();
        send(8'h00); send(8'h02); send(8'h11); send(8'h22); send(8'h33);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_nwr", 32'(wr_addr_q.size()), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        wr_addr_q.delete(); wr_data_q.delete();
        send_image(img_d, 2, 1, 8'h00);
        @(negedge clk);
        check("d_done", 32'(done), 32'd1);
        check_writes("d", img_d, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
